// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: packs an unstalled 8-bit pixel stream into WORD_BYTES-wide
// words. Each word carries a byte-enable and a frame-last flag. Words are buffered
// in a first-word-fall-through FIFO and drained over valid/ready.
// The block also tracks the frame pixel count for length checking.
module pixel_stream_packer #(
    parameter int WORD_BYTES   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid_i,
    input  logic [7:0]                    pix_data_i,
    input  logic                          pix_last_i,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic [WORD_BYTES*8-1:0]       tx_data_o,
    output logic [WORD_BYTES-1:0]         tx_keep_o,
    output logic                          tx_last_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          len_err_o
);
    localparam int IDXW = $clog2(WORD_BYTES);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int LVLW = PTRW + 1;
    localparam int CNTW = $clog2(FRAME_PIXELS) + 1;
    localparam int WW   = WORD_BYTES * 8;

    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(WORD_BYTES - 1);
    localparam logic [LVLW-1:0] FULL_LVL  = LVLW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] FRAME_CNT = CNTW'(FRAME_PIXELS);

    typedef enum logic {EMPTY, FILL} pack_state_e;

    pack_state_e      state_q;
    logic [IDXW-1:0]  idx_q;
    logic [WW-1:0]    data_q;
    logic [WORD_BYTES-1:0] keep_q;

    logic [WW-1:0]    asm_data;
    logic [WORD_BYTES-1:0] asm_keep;
    logic             complete;

    logic [WW-1:0]         mem_data_q [FIFO_DEPTH];
    logic [WORD_BYTES-1:0] mem_keep_q [FIFO_DEPTH];
    logic                  mem_last_q [FIFO_DEPTH];
    logic [PTRW-1:0]  wptr_q, rptr_q;
    logic [LVLW-1:0]  level_q, level_d;
    logic             pop, full, push_ok, drop;

    logic [CNTW-1:0]  pcnt_q, pcnt_inc;
    logic             overflow_q, len_err_q;

    // Merge the incoming pixel into the word being assembled.
    // The merged word is what gets pushed when it completes.
    always_comb begin
        asm_data = data_q;
        asm_keep = keep_q;
        asm_data[idx_q*8 +: 8] = pix_data_i;
        asm_keep[idx_q] = 1'b1;
        complete = pix_valid_i & (pix_last_i | (idx_q == LAST_IDX));
    end

    // Pack FSM: advance the byte index, or clear everything when the word completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
        end else if (pix_valid_i) begin
            if (complete) begin
                state_q <= EMPTY;
                idx_q   <= '0;
                data_q  <= '0;
                keep_q  <= '0;
            end else begin
                state_q <= FILL;
                idx_q   <= idx_q + IDXW'(1);
                data_q  <= asm_data;
                keep_q  <= asm_keep;
            end
        end
    end

    assign pop     = tx_valid_o & tx_ready_i;
    assign full    = (level_q == FULL_LVL);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = complete & (~full | pop);
    assign drop    = complete & full & ~pop;

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVLW'(1);
            2'b01:   level_d = level_q - LVLW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage. It is not reset because the outputs are gated by tx_valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data_q[wptr_q] <= asm_data;
            mem_keep_q[wptr_q] <= asm_keep;
            mem_last_q[wptr_q] <= pix_last_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PTRW'(1);
            if (pop)     rptr_q <= rptr_q + PTRW'(1);
            level_q <= level_d;
        end
    end

    assign pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + CNTW'(1);

    // Frame length tracking and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q     <= '0;
            overflow_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            if (drop) overflow_q <= 1'b1;
            if (pix_valid_i) begin
                if (pix_last_i) begin
                    if (pcnt_q + CNTW'(1) != FRAME_CNT) len_err_q <= 1'b1;
                    pcnt_q <= '0;
                end else begin
                    if (pcnt_inc == FRAME_CNT) len_err_q <= 1'b1;
                    pcnt_q <= pcnt_inc;
                end
            end
        end
    end

    assign tx_valid_o   = (level_q != '0);
    assign tx_data_o    = tx_valid_o ? mem_data_q[rptr_q] : '0;
    assign tx_keep_o    = tx_valid_o ? mem_keep_q[rptr_q] : '0;
    assign tx_last_o    = tx_valid_o & mem_last_q[rptr_q];
    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;
    assign len_err_o    = len_err_q;
endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer. A queue-based reference model holds the expected
// FIFO contents, flags and frame count. The bench compares the DUT against the
// model every cycle and adds directed checks for the named scenarios.
module tb_pixel_stream_packer;
    localparam int WB    = 8;
    localparam int DEPTH = 16;
    localparam int FRAME = 16;
    localparam int PMAX  = (1 << ($clog2(FRAME) + 1)) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_last = 1'b0;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic [7:0]  tx_keep;
    logic        tx_last;
    logic [4:0]  fifo_level;
    logic        overflow, len_err;

    pixel_stream_packer #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FRAME)) dut (
        .clk(clk), .rst(rst),
        .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_last_i(pix_last),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .tx_data_o(tx_data), .tx_keep_o(tx_keep), .tx_last_o(tx_last),
        .fifo_level_o(fifo_level), .overflow_o(overflow), .len_err_o(len_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } word_t;

    word_t      q[$];
    logic [7:0] cur[$];
    int         pcnt = 0;
    bit         m_ovf = 0, m_lerr = 0;
    int         total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all visible state against the model (called at the negedge).
    task automatic check_all(input string tag);
        chk({tag, "_valid"}, tx_valid, q.size() != 0);
        chk({tag, "_level"}, fifo_level, q.size());
        chk({tag, "_ovf"},   overflow, m_ovf);
        chk({tag, "_lerr"},  len_err, m_lerr);
        if (q.size() != 0) begin
            chk({tag, "_data"}, tx_data, q[0].data);
            chk({tag, "_keep"}, tx_keep, q[0].keep);
            chk({tag, "_last"}, tx_last, q[0].last);
        end
    endtask

    // Drive one cycle and check the pre-edge state.
    // Then advance the model through the edge, mirroring the spec rules.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r);
        word_t w;
        pix_valid = v; pix_data = d; pix_last = l; tx_ready = r;
        check_all("cyc");
        if (q.size() != 0 && r) void'(q.pop_front());
        if (v) begin
            cur.push_back(d);
            if (l) begin
                if (pcnt + 1 != FRAME) m_lerr = 1;
                pcnt = 0;
            end else begin
                if (pcnt < PMAX) pcnt++;
                if (pcnt == FRAME) m_lerr = 1;
            end
            if (l || cur.size() == WB) begin
                w.data = '0; w.keep = '0; w.last = l;
                foreach (cur[i]) begin
                    w.data[i*8 +: 8] = cur[i];
                    w.keep[i] = 1'b1;
                end
                if (q.size() < DEPTH) q.push_back(w);
                else m_ovf = 1;
                cur.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
        pix_valid = 0; pix_last = 0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1;
        pix_valid = 0; pix_last = 0;
        #1;
        q.delete(); cur.delete(); pcnt = 0; m_ovf = 0; m_lerr = 0;
        chk({tag, "_valid"}, tx_valid, 0);
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_data"},  tx_data, 0);
        chk({tag, "_keep"},  tx_keep, 0);
        chk({tag, "_last"},  tx_last, 0);
        chk({tag, "_flags"}, {overflow, len_err}, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset("rst0");

        // 1: reset mid-word with a word already buffered
        for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h50 + i), 0, 0);
        do_reset("s1_rst");

        // 2: full word, visible the cycle after the 8th pixel
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 1);
        chk("s2_valid", tx_valid, 1);
        chk("s2_word",  tx_data, 64'h0807060504030201);
        chk("s2_keep",  tx_keep, 8'hFF);
        chk("s2_last",  tx_last, 0);
        step(0, 0, 0, 1);

        // 3: short last word
        step(1, 8'hAA, 0, 1);
        step(1, 8'hBB, 0, 1);
        step(1, 8'hCC, 1, 1);
        chk("s3_word", tx_data, 64'h0000000000CCBBAA);
        chk("s3_keep", tx_keep, 8'h07);
        chk("s3_last", tx_last, 1);
        step(0, 0, 0, 1);
        do_reset("s3_rst");

        // 4: backpressure; the 17th word is dropped
        for (int i = 0; i < 17 * WB; i++) step(1, 8'($urandom_range(0, 255)), 0, 0);
        chk("s4_level", fifo_level, 16);
        chk("s4_ovf",   overflow, 1);
        for (int i = 0; i < 18; i++) step(0, 0, 0, 1);
        chk("s4_empty", fifo_level, 0);
        do_reset("s4_rst");

        // 5: gapped input with toggling ready
        for (int i = 1; i <= 8; i++) begin
            while ($urandom_range(0, 2) == 0) step(0, 0, 0, 1'($urandom_range(0, 1)));
            step(1, 8'(i), 0, 0);
        end
        for (int i = 0; i < 6; i++) begin
            if (tx_valid) chk("s5_word", tx_data, 64'h0807060504030201);
            step(0, 0, 0, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1);

        // random stress against the model
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);

        // 6: frame length
        do_reset("s6_rst");
        for (int i = 1; i <= 16; i++) step(1, 8'(i), i == 16, 1);
        chk("s6_good", len_err, 0);
        for (int i = 1; i <= 15; i++) step(1, 8'(i), i == 15, 1);
        chk("s6_short", len_err, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
